// File: rtl/mem_access_pkg.sv
// Shared constants for the RV32I memory-access stage: access sizes and FSM state encoding.
package mem_access_pkg;

    localparam logic [1:0] LS_B = 2'b00;
    localparam logic [1:0] LS_H = 2'b01;
    localparam logic [1:0] LS_W = 2'b10;

    typedef enum logic {
        MA_IDLE = 1'b0,
        MA_WAIT = 1'b1
    } ma_state_e;

endpackage

// File: rtl/ldst_align.sv
// Combinational store formatter (byte enables, replicated write data) and load extract/extend.
module ldst_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  adr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = st_data_i;
        case (size_i)
            LS_B: begin
                be_o    = 4'b0001 << adr_lo_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            LS_H: begin
                be_o    = adr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (adr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = adr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            LS_B:    ld_data_o = uns_i ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            LS_H:    ld_data_o = uns_i ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32I MA stage: runs one req/ack data-memory transaction per ld/st, stalls upstream
// meanwhile, and registers the write-back result into WB.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_ld_ma,
    input  logic        cmd_st_ma,
    input  logic        wbk_rd_reg_ma,
    input  logic [4:0]  rd_adr_ma,
    input  logic [31:0] rd_data_ma,
    input  logic [31:0] st_data_ma,
    input  logic [2:0]  ldst_code_ma,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_adr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_ma,
    output logic        misalign_ma,
    output logic        bus_err_ma,
    output logic        wbk_rd_reg_wb,
    output logic [4:0]  rd_adr_wb,
    output logic [31:0] rd_data_wb
);

    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    ma_state_e   state_q, state_d;
    logic [7:0]  cnt_q;
    logic [29:0] adr_q;
    logic [1:0]  adr_lo_q, size_q;
    logic        uns_q, we_q, wbk_q;
    logic [4:0]  rd_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        misalign_q, bus_err_q, wbk_wb_q;
    logic [4:0]  rd_adr_wb_q;
    logic [31:0] rd_data_wb_q;

    logic        idle, waiting, mem_cmd, misaligned, accept, timeout;
    logic [1:0]  al_adr, al_size;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_ld;

    assign idle    = (state_q == MA_IDLE);
    assign waiting = (state_q == MA_WAIT);
    assign mem_cmd = cmd_ld_ma | cmd_st_ma;
    assign timeout = waiting && (cnt_q == TO_LAST);

    always_comb begin
        case (ldst_code_ma[1:0])
            LS_B:    misaligned = 1'b0;
            LS_H:    misaligned = rd_data_ma[0];
            default: misaligned = (rd_data_ma[1:0] != 2'b00);
        endcase
    end

    assign accept = idle & mem_cmd & ~misaligned;

    // Aligner sees the live MA address while formatting a store, the captured one while extracting a load.
    assign al_adr  = waiting ? adr_lo_q : rd_data_ma[1:0];
    assign al_size = waiting ? size_q   : ldst_code_ma[1:0];

    ldst_align u_align (
        .adr_lo_i  (al_adr),
        .size_i    (al_size),
        .uns_i     (uns_q),
        .st_data_i (st_data_ma),
        .rdata_i   (dmem_rdata),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .ld_data_o (al_ld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= MA_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MA_IDLE: if (accept) state_d = MA_WAIT;
            MA_WAIT: if (dmem_ack || timeout) state_d = MA_IDLE;
            default: state_d = MA_IDLE;
        endcase
    end

    // Stall is gated by reset so an abandoned transaction releases upstream immediately.
    always_comb begin
        dmem_req = waiting;
        stall_ma = rst_n & (accept | (waiting & ~dmem_ack & ~timeout));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            adr_q        <= '0;
            adr_lo_q     <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
            wbk_q        <= 1'b0;
            rd_q         <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            wbk_wb_q     <= 1'b0;
            rd_adr_wb_q  <= '0;
            rd_data_wb_q <= '0;
        end else begin
            misalign_q <= idle & mem_cmd & misaligned;
            bus_err_q  <= timeout & ~dmem_ack;
            cnt_q      <= (waiting && state_d == MA_WAIT) ? cnt_q + 8'd1 : 8'd0;
            if (idle) begin
                if (mem_cmd) begin
                    wbk_wb_q <= 1'b0;
                    if (!misaligned) begin
                        adr_q    <= rd_data_ma[31:2];
                        adr_lo_q <= rd_data_ma[1:0];
                        size_q   <= ldst_code_ma[1:0];
                        uns_q    <= ldst_code_ma[2];
                        we_q     <= cmd_st_ma;
                        wbk_q    <= wbk_rd_reg_ma;
                        rd_q     <= rd_adr_ma;
                        be_q     <= al_be;
                        wdata_q  <= al_wdata;
                    end
                end else begin
                    wbk_wb_q     <= wbk_rd_reg_ma;
                    rd_adr_wb_q  <= rd_adr_ma;
                    rd_data_wb_q <= rd_data_ma;
                end
            end else if (dmem_ack && !we_q) begin
                wbk_wb_q     <= wbk_q;
                rd_adr_wb_q  <= rd_q;
                rd_data_wb_q <= al_ld;
            end else begin
                wbk_wb_q <= 1'b0;
            end
        end
    end

    assign dmem_we       = we_q;
    assign dmem_adr      = adr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign misalign_ma   = misalign_q;
    assign bus_err_ma    = bus_err_q;
    assign wbk_rd_reg_wb = wbk_wb_q;
    assign rd_adr_wb     = rd_adr_wb_q;
    assign rd_data_wb    = rd_data_wb_q;

endmodule
